// File: rtl/cpu_mult_arbiter.sv
// cpu_mult_arbiter
//
// Shares one pipelined 32x32 multiplier cell between two requesters. The cell
// returns the low 32 bits of the product. Each cycle, at most one requester is
// granted in round-robin order. The granted operands are registered into the
// cell. A tag pipeline tracks the operation, and the cell output is captured
// into that requester's response slot.
//
// Parameters:
//   MUL_LATENCY  clock edges from operands stable at the cell inputs to a valid
//                cell output (legal range 1..4)
//
// Ports:
//   clk                      single clock, rising edge
//   reset_n                  asynchronous active-low reset
//   reqN_valid               requester N has an operation pending
//   reqN_src1, reqN_src2     requester N operands (held until accepted)
//   reqN_ready               combinational grant; transfer on valid && ready
//   rspN_valid               requester N result slot full
//   rspN_result              low 32 bits of the unsigned product
//   rspN_ack                 requester N consumes the result when rspN_valid
//   mul_src1, mul_src2       registered operands driven into the cell
//   mul_result               cell product, low 32 bits
//   busy                     an operation is in flight or a slot is full
module cpu_mult_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_result,
    input  logic        rsp0_ack,
    input  logic        req1_valid,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_result,
    input  logic        rsp1_ack,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_result,
    output logic        busy
);

    logic [1:0]           req_valid;
    logic [1:0]           rsp_ack;
    logic [1:0]           elig;
    logic [1:0]           grant;
    logic [1:0]           inflight;
    logic [1:0]           rsp_valid;
    logic [1:0]           done;
    logic                 last_grant;
    logic [MUL_LATENCY:0] tag_valid;
    logic [MUL_LATENCY:0] tag_id;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ack   = {rsp1_ack, rsp0_ack};

    // A requester may issue only when it has nothing in flight and its slot is
    // empty or being emptied this cycle. This limits each requester to one
    // outstanding op, so a slot can never be overwritten.
    assign elig = req_valid & ~inflight & (~rsp_valid | rsp_ack);

    // Round-robin grant. A tie goes to the requester that did not win last
    // time. Grants are held off while reset is asserted, so ready reads zero
    // during reset.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            if (elig == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // The last tag stage lines up with the cell output, so a valid tag there
    // says whose product is on mul_result this cycle.
    assign done = {tag_valid[MUL_LATENCY] &  tag_id[MUL_LATENCY],
                   tag_valid[MUL_LATENCY] & ~tag_id[MUL_LATENCY]};

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];

    // busy comes only from registered state, so it has no path from the inputs.
    assign busy = (|inflight) | (|rsp_valid);

    // Main state update: operand registers, tag pipeline, round-robin pointer,
    // in-flight flags and response slots. Completion cannot coincide with an
    // ack of the same slot, because a requester with an op in flight always
    // has an empty slot. An ack and a new grant in the same cycle both take
    // effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_src1    <= '0;
            mul_src2    <= '0;
            tag_valid   <= '0;
            tag_id      <= '0;
            last_grant  <= 1'b1;
            inflight    <= '0;
            rsp_valid   <= '0;
            rsp0_result <= '0;
            rsp1_result <= '0;
        end else begin
            tag_valid <= {tag_valid[MUL_LATENCY-1:0], |grant};
            tag_id    <= {tag_id[MUL_LATENCY-1:0], grant[1]};
            if (|grant) begin
                mul_src1   <= grant[1] ? req1_src1 : req0_src1;
                mul_src2   <= grant[1] ? req1_src2 : req0_src2;
                last_grant <= grant[1];
            end
            inflight  <= (inflight & ~done) | grant;
            rsp_valid <= (rsp_valid & ~rsp_ack) | done;
            if (done[0]) begin
                rsp0_result <= mul_result;
            end
            if (done[1]) begin
                rsp1_result <= mul_result;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mult_arbiter.sv
// tb_cpu_mult_arbiter
//
// Bench for cpu_mult_arbiter. One instance runs at MUL_LATENCY=1 and carries
// the main traffic. A second instance runs at MUL_LATENCY=2 and is used for
// the mid-operation reset scenario. Each instance has a behavioural pipelined
// multiplier cell attached. Expected grants and results are queued when
// stimulus is issued. A monitor pops and compares them whenever the DUT shows
// a grant or hands over a result.
module tb_cpu_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        req0_valid, req1_valid;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_ack, rsp1_ack;
    logic [31:0] mul_src1, mul_src2, mul_result;
    logic        busy;

    logic        r2_req0_valid, r2_req1_valid;
    logic [31:0] r2_req0_src1, r2_req0_src2, r2_req1_src1, r2_req1_src2;
    logic        r2_req0_ready, r2_req1_ready;
    logic        r2_rsp0_valid, r2_rsp1_valid;
    logic [31:0] r2_rsp0_result, r2_rsp1_result;
    logic        r2_rsp0_ack, r2_rsp1_ack;
    logic [31:0] r2_mul_src1, r2_mul_src2, r2_mul_result;
    logic        r2_busy;

    logic [31:0] cell1_q;
    logic [31:0] cell2_a, cell2_b;

    logic [31:0] op0_a[$], op0_b[$], op1_a[$], op1_b[$];
    logic [31:0] exp_rsp0[$], exp_rsp1[$], exp_gnt[$];

    int          total = 0;
    int          bad = 0;
    bit          fire0, fire1;

    cpu_mult_arbiter #(.MUL_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
        .rsp0_ack(rsp0_ack),
        .req1_valid(req1_valid), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
        .rsp1_ack(rsp1_ack),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
        .busy(busy)
    );

    cpu_mult_arbiter #(.MUL_LATENCY(2)) dut_l2 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(r2_req0_valid), .req0_src1(r2_req0_src1), .req0_src2(r2_req0_src2),
        .req0_ready(r2_req0_ready), .rsp0_valid(r2_rsp0_valid), .rsp0_result(r2_rsp0_result),
        .rsp0_ack(r2_rsp0_ack),
        .req1_valid(r2_req1_valid), .req1_src1(r2_req1_src1), .req1_src2(r2_req1_src2),
        .req1_ready(r2_req1_ready), .rsp1_valid(r2_rsp1_valid), .rsp1_result(r2_rsp1_result),
        .rsp1_ack(r2_rsp1_ack),
        .mul_src1(r2_mul_src1), .mul_src2(r2_mul_src2), .mul_result(r2_mul_result),
        .busy(r2_busy)
    );

    always #5 clk = ~clk;

    // Multiplier cells. The first has one register stage and the second has
    // two, so each matches the latency of its arbiter instance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell1_q <= '0;
            cell2_a <= '0;
            cell2_b <= '0;
        end else begin
            cell1_q <= mul_src1 * mul_src2;
            cell2_a <= r2_mul_src1 * r2_mul_src2;
            cell2_b <= cell2_a;
        end
    end
    assign mul_result    = cell1_q;
    assign r2_mul_result = cell2_b;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_unexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=event expected=none at %0t", name, $time);
    endtask

    task automatic apply_stimulus(input int req, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] expv);
        if (req == 0) begin
            op0_a.push_back(a);
            op0_b.push_back(b);
            exp_rsp0.push_back(expv);
        end else begin
            op1_a.push_back(a);
            op1_b.push_back(b);
            exp_rsp1.push_back(expv);
        end
    endtask

    // Requester 0 driver. It presents queued ops back to back and holds each
    // op until it has been accepted.
    initial begin
        req0_valid = 1'b0;
        req0_src1  = '0;
        req0_src2  = '0;
        forever begin
            @(negedge clk);
            fire0 = reset_n && req0_valid && req0_ready;
            @(posedge clk);
            #1;
            if (fire0) req0_valid = 1'b0;
            if (!req0_valid && op0_a.size() > 0) begin
                req0_src1  = op0_a.pop_front();
                req0_src2  = op0_b.pop_front();
                req0_valid = 1'b1;
            end
        end
    end

    // Requester 1 driver, same behaviour as requester 0.
    initial begin
        req1_valid = 1'b0;
        req1_src1  = '0;
        req1_src2  = '0;
        forever begin
            @(negedge clk);
            fire1 = reset_n && req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (fire1) req1_valid = 1'b0;
            if (!req1_valid && op1_a.size() > 0) begin
                req1_src1  = op1_a.pop_front();
                req1_src2  = op1_b.pop_front();
                req1_valid = 1'b1;
            end
        end
    end

    // Monitor: grants and consumed results are compared against the queues.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                check_output("grant_onehot", {31'b0, req0_ready & req1_ready}, 32'd0);
                if (exp_gnt.size() == 0) report_unexpected("grant_unexpected");
                else check_output("grant_id", {31'b0, req1_valid & req1_ready},
                                  exp_gnt.pop_front());
            end
            if (rsp0_valid && rsp0_ack) begin
                if (exp_rsp0.size() == 0) report_unexpected("rsp0_unexpected");
                else check_output("rsp0_result", rsp0_result, exp_rsp0.pop_front());
            end
            if (rsp1_valid && rsp1_ack) begin
                if (exp_rsp1.size() == 0) report_unexpected("rsp1_unexpected");
                else check_output("rsp1_result", rsp1_result, exp_rsp1.pop_front());
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_rsp0.size() == 0 && exp_rsp1.size() == 0 && exp_gnt.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output(name, 32'd0, 32'd1);
    endtask

    task automatic wait_accept0(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output(name, 32'd0, 32'd1);
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          seen;
        bit          ok;
        logic [31:0] a, b;

        reset_n       = 1'b0;
        rsp0_ack      = 1'b0;
        rsp1_ack      = 1'b1;
        r2_req0_valid = 1'b0;
        r2_req1_valid = 1'b0;
        r2_req0_src1  = '0;
        r2_req0_src2  = '0;
        r2_req1_src1  = '0;
        r2_req1_src2  = '0;
        r2_rsp0_ack   = 1'b1;
        r2_rsp1_ack   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check_output("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        check_output("rst_rsp0_result", rsp0_result, 32'd0);
        check_output("rst_mul_src1", mul_src1, 32'd0);
        check_output("rst_mul_src2", mul_src2, 32'd0);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single op: 3 x 5, latency of two edges, busy clears after ack
        @(negedge clk);
        apply_stimulus(0, 32'd3, 32'd5, 32'd15);
        exp_gnt.push_back(32'd0);
        wait_accept0("t1_accept_timeout");
        @(negedge clk);
        check_output("t1_valid_after_e0", {31'b0, rsp0_valid}, 32'd0);
        check_output("t1_busy_inflight", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check_output("t1_valid_after_e1", {31'b0, rsp0_valid}, 32'd0);
        @(negedge clk);
        check_output("t1_valid_after_e2", {31'b0, rsp0_valid}, 32'd1);
        check_output("t1_result", rsp0_result, 32'd15);
        @(posedge clk);
        #1 rsp0_ack = 1'b1;
        @(posedge clk);
        #1 rsp0_ack = 1'b0;
        @(negedge clk);
        check_output("t1_busy_after_ack", {31'b0, busy}, 32'd0);

        // Simultaneous requests straight out of reset: requester 0 wins the tie
        @(posedge clk);
        #1 reset_n = 1'b0;
        rsp0_ack = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 32'h0001_0000, 32'd3, 32'h0003_0000);
        apply_stimulus(1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        exp_gnt.push_back(32'd0);
        exp_gnt.push_back(32'd1);
        wait_idle("t2_drain_timeout");

        // Truncation to the low word
        apply_stimulus(0, 32'hFFFF_0001, 32'h0001_0001, 32'h0000_0001);
        apply_stimulus(1, 32'h8000_0000, 32'd2, 32'h0000_0000);
        exp_gnt.push_back(32'd0);
        exp_gnt.push_back(32'd1);
        wait_idle("t3_drain_timeout");

        // Fairness with both requesters continuously valid and acks held high
        for (int i = 0; i < 4; i++) begin
            a = 32'h1234_5678 + i;
            b = i + 3;
            apply_stimulus(0, a, b, a * b);
            a = 32'hFFFF_FFF0 - i;
            b = 32'h0001_0001 * (i + 1);
            apply_stimulus(1, a, b, a * b);
            exp_gnt.push_back(32'd0);
            exp_gnt.push_back(32'd1);
        end
        wait_idle("t4_drain_timeout");

        // Backpressure: slot 0 held full, requester 1 keeps being served
        @(posedge clk);
        #1 rsp0_ack = 1'b0;
        @(negedge clk);
        apply_stimulus(0, 32'd1000, 32'd1000, 32'd1000000);
        apply_stimulus(0, 32'd12345, 32'd6789, 32'd83810205);
        apply_stimulus(1, 32'd21, 32'd2, 32'd42);
        apply_stimulus(1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001);
        apply_stimulus(1, 32'd7, 32'd6, 32'd42);
        exp_gnt.push_back(32'd0);
        exp_gnt.push_back(32'd1);
        exp_gnt.push_back(32'd1);
        exp_gnt.push_back(32'd1);
        exp_gnt.push_back(32'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp0_valid && req0_valid) check_output("t5_ready0_blocked", {31'b0, req0_ready}, 32'd0);
            if (exp_rsp1.size() == 0 && rsp0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_output("t5_wait_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rsp0_ack = 1'b1;
        @(negedge clk);
        check_output("t5_grant_with_ack", {31'b0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 rsp0_ack = 1'b0;
        @(negedge clk);
        check_output("t5_slot_emptied", {31'b0, rsp0_valid}, 32'd0);
        check_output("t5_result_held", rsp0_result, 32'd1000000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp0_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_output("t5_refill_timeout", 32'd0, 32'd1);
        check_output("t5_refill_result", rsp0_result, 32'd83810205);
        @(posedge clk);
        #1 rsp0_ack = 1'b1;
        wait_idle("t5_drain_timeout");

        // Reset right after accept at MUL_LATENCY=2 discards the op
        @(posedge clk);
        #1 r2_req0_valid = 1'b1;
        r2_req0_src1 = 32'd7;
        r2_req0_src2 = 32'd9;
        @(negedge clk);
        check_output("t6_ready_before_reset", {31'b0, r2_req0_ready}, 32'd1);
        @(posedge clk);
        #1 r2_req0_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check_output("t6_rst_busy", {31'b0, r2_busy}, 32'd0);
        check_output("t6_rst_mul_src1", r2_mul_src1, 32'd0);
        check_output("t6_rst_rsp_valid", {31'b0, r2_rsp0_valid}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (r2_rsp0_valid || r2_rsp1_valid || r2_busy || r2_rsp0_result != 0) seen = 1'b1;
        end
        check_output("t6_no_ghost_response", {31'b0, seen}, 32'd0);

        // After that reset the next tie goes to requester 0; latency is 3 edges
        @(posedge clk);
        #1 r2_req0_valid = 1'b1;
        r2_req1_valid = 1'b1;
        r2_req1_src1  = 32'd11;
        r2_req1_src2  = 32'd13;
        @(negedge clk);
        check_output("t6_tie_grant", {30'b0, r2_req1_ready, r2_req0_ready}, 32'd1);
        @(posedge clk);
        #1 r2_req0_valid = 1'b0;
        @(negedge clk);
        check_output("t6_second_grant", {30'b0, r2_req1_ready, r2_req0_ready}, 32'd2);
        @(posedge clk);
        #1 r2_req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("t6_valid_after_e2", {31'b0, r2_rsp0_valid}, 32'd0);
        @(negedge clk);
        check_output("t6_valid_after_e3", {31'b0, r2_rsp0_valid}, 32'd1);
        check_output("t6_result0", r2_rsp0_result, 32'd63);
        @(negedge clk);
        check_output("t6_valid1", {31'b0, r2_rsp1_valid}, 32'd1);
        check_output("t6_result1", r2_rsp1_result, 32'd143);

        check_output("end_gnt_queue", exp_gnt.size(), 32'd0);
        check_output("end_rsp_queues", exp_rsp0.size() + exp_rsp1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
